// File: rtl/goldschmidt_pkg.sv
// Shared constants and encodings for the Goldschmidt divider datapath.
//   ONE_Q15 : 1.0 in Q1.15
//   FRAC    : number of fraction bits in Q1.15
//   right_mux_e : encodings of the multiplier right-operand select
package goldschmidt_pkg;

    localparam logic [15:0] ONE_Q15 = 16'h8000;
    localparam int          FRAC    = 15;

    typedef enum logic [1:0] {
        RM_K    = 2'b00,
        RM_IA   = 2'b01,
        RM_ONE  = 2'b10,
        RM_ZERO = 2'b11
    } right_mux_e;

endpackage

// File: rtl/goldschmidt_divider_fx_mul_q15.sv
// Combinational Q1.15 x Q1.15 multiplier with truncation and saturation.
//   a_i, b_i : Q1.15 unsigned operands
//   p_o      : Q1.15 product, truncated; 0xFFFF when the product is >= 2.0
module fx_mul_q15
    import goldschmidt_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] p_o
);

    logic [31:0] prod_s;

    // Full-width product, then drop the extra fraction bits or saturate.
    always_comb begin
        prod_s = 32'(a_i) * 32'(b_i);
        if (prod_s[31]) begin
            // Bit 31 set means the Q2.30 value is >= 2.0, beyond Q1.15 range.
            p_o = 16'hFFFF;
        end else begin
            p_o = prod_s[FRAC +: 16];
        end
    end

endmodule

// File: rtl/goldschmidt_divider.sv
// Goldschmidt iterative divider datapath, Q ~= A / B, sequenced externally.
//   clk, reset           : clock, asynchronous active-high clear
//   A, B                 : numerator / normalized divisor, Q1.15
//   IA0..IA3             : reciprocal seeds (Q0.16), indexed by B[14:13]
//   kSave, dSave, nSave  : register load strobes (dSave wins over nSave)
//   kNextSel             : 1 = initial pass (seed, A/B), 0 = refinement pass
//   rightMux             : multiplier right operand select
//   Q, R                 : N register (quotient) and D register (residual)
module goldschmidt_divider
    import goldschmidt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] IA0,
    input  logic [WIDTH-1:0] IA1,
    input  logic [WIDTH-1:0] IA2,
    input  logic [WIDTH-1:0] IA3,
    input  logic             kSave,
    input  logic             dSave,
    input  logic             nSave,
    input  logic             kNextSel,
    input  logic [1:0]       rightMux,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
);

    logic [15:0] k_q, k_d;
    logic [15:0] d_q, d_d;
    logic [15:0] n_q, n_d;
    logic [15:0] ia_raw_s;
    logic [15:0] ia_sel_s;
    logic [15:0] k_next_s;
    logic [15:0] left_s;
    logic [15:0] right_s;
    logic [15:0] mul_s;
    right_mux_e  rm_s;

    assign rm_s = right_mux_e'(rightMux);

    // Seed lookup on the two bits below the leading one of B.
    always_comb begin
        case (B[14:13])
            2'b00:   ia_raw_s = IA0;
            2'b01:   ia_raw_s = IA1;
            2'b10:   ia_raw_s = IA2;
            2'b11:   ia_raw_s = IA3;
            default: ia_raw_s = 16'h0000;
        endcase
        // Q0.16 -> Q1.15 is a plain right shift by one.
        ia_sel_s = ia_raw_s >> 1;
    end

    // Next scale factor: seed, or 2 - D (wraps to 0 when D is 0).
    always_comb begin
        if (kNextSel) begin
            k_next_s = ia_sel_s;
        end else begin
            k_next_s = 16'h0000 - d_q;
        end
    end

    // Left operand: divisor path when D is being written, numerator path otherwise.
    always_comb begin
        if (dSave) begin
            left_s = kNextSel ? B : d_q;
        end else begin
            left_s = kNextSel ? A : n_q;
        end
    end

    // Right operand; K bypasses the register when it is written this cycle.
    always_comb begin
        case (rm_s)
            RM_K:    right_s = kSave ? k_next_s : k_q;
            RM_IA:   right_s = ia_sel_s;
            RM_ONE:  right_s = ONE_Q15;
            RM_ZERO: right_s = 16'h0000;
            default: right_s = 16'h0000;
        endcase
    end

    fx_mul_q15 u_mul (
        .a_i (left_s),
        .b_i (right_s),
        .p_o (mul_s)
    );

    // Next-state for the working registers; D takes priority over N.
    always_comb begin
        k_d = k_q;
        d_d = d_q;
        n_d = n_q;
        if (kSave) begin
            k_d = k_next_s;
        end else begin
            k_d = k_q;
        end
        if (dSave) begin
            d_d = mul_s;
        end else if (nSave) begin
            n_d = mul_s;
        end else begin
            d_d = d_q;
            n_d = n_q;
        end
    end

    // Working register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= 16'h0000;
            d_q <= 16'h0000;
            n_q <= 16'h0000;
        end else begin
            k_q <= k_d;
            d_q <= d_d;
            n_q <= n_d;
        end
    end

    assign Q = n_q;
    assign R = d_q;

endmodule

// File: tb/tb_goldschmidt_divider.sv
// Directed self-checking bench for goldschmidt_divider.
module tb_goldschmidt_divider;

    logic        clk;
    logic        reset;
    logic [15:0] A, B;
    logic [15:0] IA0, IA1, IA2, IA3;
    logic        kSave, dSave, nSave, kNextSel;
    logic [1:0]  rightMux;
    logic [15:0] Q, R;

    int checks;
    int failures;

    goldschmidt_divider dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .IA0      (IA0),
        .IA1      (IA1),
        .IA2      (IA2),
        .IA3      (IA3),
        .kSave    (kSave),
        .dSave    (dSave),
        .nSave    (nSave),
        .kNextSel (kNextSel),
        .rightMux (rightMux),
        .Q        (Q),
        .R        (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive strobes at the falling edge, let one rising edge pass, settle.
    task automatic step(input logic ks, input logic ds, input logic ns,
                        input logic kns, input logic [1:0] rm);
        @(negedge clk);
        kSave = ks; dSave = ds; nSave = ns; kNextSel = kns; rightMux = rm;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_strobes();
        kSave    = 1'($urandom);
        dSave    = 1'($urandom);
        nSave    = 1'($urandom);
        kNextSel = 1'($urandom);
        rightMux = 2'($urandom);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        A = 16'h8000; B = 16'h8000;
        // Q1.15 seeds: 0x7333, 0x599A, 0x4F5C, 0x451E
        IA0 = 16'hE666; IA1 = 16'hB334; IA2 = 16'h9EB8; IA3 = 16'h8A3D;
        kSave = 1'b0; dSave = 1'b0; nSave = 1'b0; kNextSel = 1'b0; rightMux = 2'b00;

        // Reset with random strobes.
        #2;
        reset = 1'b1;
        rand_strobes();
        #1;
        chk("reset_q", Q, 16'h0000);
        chk("reset_r", R, 16'h0000);
        repeat (3) begin
            @(negedge clk);
            rand_strobes();
        end
        #1;
        chk("reset_hold_q", Q, 16'h0000);
        chk("reset_hold_r", R, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // 1.0 / 1.0, canonical sequence.
        A = 16'h8000; B = 16'h8000;
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01); chk("s1_c1_r", R, 16'h7333);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00); chk("s1_c2_q", Q, 16'h7333);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00); chk("s1_c3_r", R, 16'h7EB8);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); chk("s1_c4_q", Q, 16'h7EB8);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00); chk("s1_c5_r", R, 16'h7FFC);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); chk("s1_c6_q", Q, 16'h7FFC);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("s1_c10_q", Q, 16'h7FFF);
        chk("s1_c10_r", R, 16'h7FFF);

        // 0.5 / 1.5 -> 1/3 (seed IA2, K0 = 0x4F5C).
        A = 16'h4000; B = 16'hC000;
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01); chk("s2_c1_r", R, 16'h770A);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00); chk("s2_c2_q", Q, 16'h27AE);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00); chk("s2_c3_r", R, 16'h7F5F);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); chk("s2_c4_q", Q, 16'h2A75);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("s2_c10_q", Q, 16'h2AAA);
        chk("s2_c10_r", R, 16'h7FFF);

        // Both D and N strobes: D = B x 1.0, N holds.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
        chk("pass_r", R, 16'hC000);
        chk("dn_both_q", Q, 16'h2AAA);
        // All strobes low: everything holds.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 2'($urandom));
            chk("hold_q", Q, 16'h2AAA);
            chk("hold_r", R, 16'hC000);
        end
        // Zero right operand.
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("zero_r", R, 16'h0000);

        // Seed table index, first step only.
        B = 16'h8000; step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01); chk("tab0_r", R, 16'h7333);
        B = 16'hA000; step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01); chk("tab1_r", R, 16'h7000);
        B = 16'hC000; step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01); chk("tab2_r", R, 16'h770A);
        // 0xE000 x 0x451E >> 15 = 7 x 0x451E / 4 = 30964.5 -> 0x78F4
        B = 16'hE000; step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01); chk("tab3_r", R, 16'h78F4);

        // Saturation: N = 0xFFFF x 1.0, then N x (2 - 0x78F4 = 0x870C) >= 2.0.
        A = 16'hFFFF;
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b10); chk("ld_n_q", Q, 16'hFFFF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b00); chk("sat_q", Q, 16'hFFFF);
        chk("sat_r_hold", R, 16'h78F4);

        // Reset mid-sequence at c5, then restart.
        A = 16'h8000; B = 16'h8000;
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); chk("mid_c4_q", Q, 16'h7EB8);
        @(negedge clk);
        kSave = 1'b1; dSave = 1'b1; nSave = 1'b0; kNextSel = 1'b0; rightMux = 2'b00;
        reset = 1'b1;
        #1;
        chk("mid_reset_q", Q, 16'h0000);
        chk("mid_reset_r", R, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01); chk("rs_c1_r", R, 16'h7333);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00); chk("rs_c2_q", Q, 16'h7333);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00); chk("rs_c5_r", R, 16'h7FFC);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        chk("rs_c10_q", Q, 16'h7FFF);
        chk("rs_c10_r", R, 16'h7FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
